// File: rtl/mem_stream_reader.sv
// Sequential RAM read engine: streams `count` words from `base_addr` as valid/ready.
// Reads are issued back-to-back; a 2-entry buffer absorbs consumer backpressure.
module mem_stream_reader #(
    parameter int WORD_SIZE = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(WORD_SIZE)-1:0]   base_addr,
    input  logic [$clog2(WORD_SIZE):0]     count,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(WORD_SIZE)-1:0]   mem_addr,
    output logic                           mem_we,
    output logic [WORD_SIZE-1:0]           mem_din,
    input  logic [WORD_SIZE-1:0]           mem_dout,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_SIZE-1:0]           out_data,
    output logic                           out_last
);
    localparam int ADDR_SIZE = $clog2(WORD_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE:0]     count_q, count_d;
    logic [ADDR_SIZE:0]     issued_q, issued_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             fill_q, fill_d;
    logic [WORD_SIZE-1:0]   buf_data_q [2];
    logic [WORD_SIZE-1:0]   buf_data_d [2];
    logic                   buf_last_q [2];
    logic                   buf_last_d [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic       final_issue;
    logic [2:0] occupancy;

    always_comb begin
        pop         = (fill_q != 2'd0) && out_ready;
        push        = inflight_q;
        // Words already committed (buffered or returning) minus the one leaving now.
        occupancy   = {1'b0, fill_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = (state_q == S_RUN) && (occupancy < 3'd2);
        final_issue = issue && ((issued_q + 1'b1) == count_q);
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        count_d         = count_q;
        issued_d        = issued_q;
        inflight_d      = issue;
        inflight_last_d = final_issue;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        fill_d          = fill_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (issue) begin
            addr_d   = addr_q + 1'b1;
            issued_d = issued_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d  = count;
                    issued_d = '0;
                    if (count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = base_addr;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (final_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && fill_d == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            count_q         <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            fill_q          <= 2'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            count_q         <= count_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fill_q          <= fill_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_comb begin
                buf_data_d[gi] = buf_data_q[gi];
                buf_last_d[gi] = buf_last_q[gi];
                if (push && (wr_ptr_q == 1'(gi))) begin
                    buf_data_d[gi] = mem_dout;
                    buf_last_d[gi] = inflight_last_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_data_q[gi] <= '0;
                    buf_last_q[gi] <= 1'b0;
                end else begin
                    buf_data_q[gi] <= buf_data_d[gi];
                    buf_last_q[gi] <= buf_last_d[gi];
                end
            end
        end
    endgenerate

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_addr  = addr_q;
    assign mem_we    = 1'b0;
    assign mem_din   = '0;
    assign out_valid = (fill_q != 2'd0);
    assign out_data  = out_valid ? buf_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid & buf_last_q[rd_ptr_q];

endmodule
